// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the DAC SPI transmitter: FSM state codes, frame width, command prefix.
package dac_spi_tx_pkg;

    localparam int         DAC_FRAME_W = 24;
    localparam logic [7:0] DAC_CMD     = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4,
        ST_LDAC  = 3'd5
    } dac_state_e;

endpackage

// File: rtl/dac_spi_tx_if.sv
// SPI pins toward the external DAC; dac_ldac_n exists only when DAC_LDAC_EN is defined.
interface dac_spi_tx_if;
    logic dac_sclk;
    logic dac_mosi;
    logic dac_sync_n;
`ifdef DAC_LDAC_EN
    logic dac_ldac_n;
`endif

    modport master (
        output dac_sclk,
        output dac_mosi,
        output dac_sync_n
`ifdef DAC_LDAC_EN
        , output dac_ldac_n
`endif
    );

    modport slave (
        input dac_sclk,
        input dac_mosi,
        input dac_sync_n
`ifdef DAC_LDAC_EN
        , input dac_ldac_n
`endif
    );
endinterface

// File: rtl/dac_spi_tx_sample_tick_gen.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1, registered 1-cycle tick on each wrap.
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 2500
) (
    input  logic clk_100M,
    input  logic rst,
    output logic tick
);
    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(SAMPLE_DIV - 1));

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        tick_d = wrap;
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/dac_spi_tx.sv
// Captures dac_sample on each sample tick and shifts {CMD, offset-binary sample} to an SPI DAC.
// Optional LDAC pulse after each frame when DAC_LDAC_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for sample tick
//  SETUP | sync_n low, first bit on mosi, sclk low
//  SHIFT | 24 sclk periods, high phase then low phase
//  HOLD  | sclk low, sync_n still low
//  GAP   | sync_n high, mosi low
//  LDAC  | ldac_n low (DAC_LDAC_EN only)
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int               DATA_W     = 16,
    parameter int               CMD_W      = 8,
    parameter logic [CMD_W-1:0] CMD        = CMD_W'(DAC_CMD),
    parameter int               SCLK_DIV   = 4,
    parameter int               SAMPLE_DIV = 2500
) (
    input  logic              clk_100M,
    input  logic              rst,
    input  logic [DATA_W-1:0] dac_sample,
    dac_spi_tx_if.master      spi,
    output logic              sample_strobe,
    output logic              busy,
    output logic              overrun
);
    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BC_W    = $clog2(FRAME_W + 1);
    localparam int HC_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [HC_W-1:0] HC_RELOAD = HC_W'(SCLK_DIV - 1);

    dac_state_e         state_q, state_d;
    logic [HC_W-1:0]    hcnt_q, hcnt_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               mosi_q, mosi_d;
    logic               sclk_q, sclk_d;
    logic               sync_n_q, sync_n_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
`ifdef DAC_LDAC_EN
    logic               ldac_n_q, ldac_n_d;
`endif

    logic               tick;
    logic               hc_zero;
    logic [FRAME_W-1:0] frame;

    sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk_100M (clk_100M),
        .rst      (rst),
        .tick     (tick)
    );

    // Inverting the sign bit maps two's complement onto the DAC's offset-binary code.
    assign frame   = {CMD, ~dac_sample[DATA_W-1], dac_sample[DATA_W-2:0]};
    assign hc_zero = (hcnt_q == '0);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hc_zero ? hcnt_q : hcnt_q - HC_W'(1);
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        busy_d    = busy_q;
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));
`ifdef DAC_LDAC_EN
        ldac_n_d  = ldac_n_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d  = ST_SETUP;
                    mosi_d   = frame[FRAME_W-1];
                    shreg_d  = frame << 1;
                    sync_n_d = 1'b0;
                    busy_d   = 1'b1;
                    hcnt_d   = HC_RELOAD;
                    bcnt_d   = '0;
                end
            end
            ST_SETUP: begin
                if (hc_zero) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    hcnt_d  = HC_RELOAD;
                end
            end
            ST_SHIFT: begin
                if (hc_zero) begin
                    hcnt_d = HC_RELOAD;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bcnt_d = bcnt_q + BC_W'(1);
                    end else if (bcnt_q == BC_W'(FRAME_W)) begin
                        state_d = ST_HOLD;
                    end else begin
                        // First bit was presented in SETUP; later bits advance on rising edges.
                        sclk_d  = 1'b1;
                        mosi_d  = shreg_q[FRAME_W-1];
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            ST_HOLD: begin
                if (hc_zero) begin
                    state_d  = ST_GAP;
                    sync_n_d = 1'b1;
                    mosi_d   = 1'b0;
                    hcnt_d   = HC_RELOAD;
                end
            end
            ST_GAP: begin
                if (hc_zero) begin
`ifdef DAC_LDAC_EN
                    state_d  = ST_LDAC;
                    ldac_n_d = 1'b0;
                    hcnt_d   = HC_RELOAD;
`else
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
`endif
                end
            end
            ST_LDAC: begin
`ifdef DAC_LDAC_EN
                if (hc_zero) begin
                    state_d  = ST_IDLE;
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sync_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef DAC_LDAC_EN
            ldac_n_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
`ifdef DAC_LDAC_EN
            ldac_n_q  <= ldac_n_d;
`endif
        end
    end

    assign sample_strobe  = (state_q == ST_IDLE) && tick && !rst;
    assign busy           = busy_q;
    assign overrun        = overrun_q;
    assign spi.dac_sclk   = sclk_q;
    assign spi.dac_mosi   = mosi_q;
    assign spi.dac_sync_n = sync_n_q;
`ifdef DAC_LDAC_EN
    assign spi.dac_ldac_n = ldac_n_q;
`endif
endmodule
